// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Digit maxima follow the HH:MM:SS borrow chain, LSB first.
package timer_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_e;

   localparam logic [3:0] S0_MAX       = 4'd9;
   localparam logic [3:0] S1_MAX       = 4'd5;
   localparam logic [3:0] M0_MAX       = 4'd9;
   localparam logic [3:0] M1_MAX       = 4'd5;
   localparam logic [3:0] H0_MAX       = 4'd9;
   localparam logic [3:0] H1_MAX       = 4'd2;
   localparam logic [3:0] HOUR_MAX_LOW = 4'd3;

   // Packed {H1,H0,M1,M0,S1,S0} so digit i sits at bits [4*i +: 4].
   localparam logic [23:0] DIGIT_MAX_VEC = {H1_MAX, H0_MAX, M1_MAX, M0_MAX, S1_MAX, S0_MAX};

   function automatic logic bcd_time_valid(input logic [23:0] t);
      logic [3:0] h1, h0, m1, m0, s1, s0;
      {h1, h0, m1, m0, s1, s0} = t;
      return (s0 <= S0_MAX) && (s1 <= S1_MAX) && (m0 <= M0_MAX) && (m1 <= M1_MAX) &&
             (h1 <= H1_MAX) && (h0 <= H0_MAX) && ((h1 != H1_MAX) || (h0 <= HOUR_MAX_LOW));
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown chain: loads, decrements, and borrows
// from the next digit when it rolls from 0 back to its maximum.
module bcd_down_digit #(
   parameter bit RELOAD = 1'b1
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   input  logic [3:0] digit_max,
   output logic [3:0] digit,
   output logic       borrow
);

   logic [3:0] digit_q, digit_d;

   // NOTE: give every always_comb output a default first so no path infers a latch.
   always_comb begin
      digit_d = digit_q;
      if (load) begin
         digit_d = load_val;
      end else if (dec) begin
         digit_d = (digit_q == 4'd0) ? (RELOAD ? digit_max : 4'd0) : digit_q - 4'd1;
      end
   end

   // NOTE: non-blocking assignments so all six digits update from pre-edge values.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) digit_q <= 4'd0;
      else         digit_q <= digit_d;
   end

   assign digit  = digit_q;
   assign borrow = dec && (digit_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// HH:MM:SS BCD countdown timer: load/start/stop control, prescaled decrement
// through a six-digit borrow chain, and expiry at 00:00:00.
module bcd_countdown_timer
   import timer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100000000
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        load,
   input  logic [23:0] setValue,
   input  logic        start,
   input  logic        stop,
   output logic [23:0] value,
   output logic        running,
   output logic        done,
   output logic        expired,
   output logic        loadErr
);

   localparam int unsigned        PRESC_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

   state_e             state_q, state_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               running_q, running_d;
   logic               done_q, done_d;
   logic               expired_q, expired_d;
   logic               load_err_q, load_err_d;

   logic               load_ok;
   logic               tick;
   logic [6:0]         dec_chain;

   assign load_ok      = bcd_time_valid(setValue);
   // Any load, accepted or not, suppresses the decrement for that cycle.
   assign tick         = (state_q == RUN) && (presc_q == PRESC_MAX) && !load;
   assign dec_chain[0] = tick;

   for (genvar i = 0; i < 6; i++) begin : g_digit
      bcd_down_digit #(.RELOAD(i != 5)) u_digit (
         .clk      (clk),
         .resetN   (resetN),
         .load     (load && load_ok),
         .load_val (setValue[4*i +: 4]),
         .dec      (dec_chain[i]),
         .digit_max(DIGIT_MAX_VEC[4*i +: 4]),
         .digit    (value[4*i +: 4]),
         .borrow   (dec_chain[i+1])
      );
   end

   // A borrow out of H1 would mean 00:00:00 was decremented.
   assert property (@(posedge clk) disable iff (!resetN) !dec_chain[6]);

   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      done_d     = 1'b0;
      load_err_d = 1'b0;
      if (load) begin
         if (load_ok) begin
            state_d = IDLE;
            presc_d = '0;
         end else begin
            load_err_d = 1'b1;
         end
      end else begin
         unique case (state_q)
            IDLE: if (start && !stop && (value != '0)) begin
               state_d = RUN;
               presc_d = '0;
            end
            RUN: begin
               if (tick) begin
                  presc_d = '0;
                  if (value == 24'h000001) begin
                     state_d = EXPIRED;
                     done_d  = 1'b1;
                  end
               end else begin
                  presc_d = presc_q + PRESC_W'(1);
               end
               if (stop && (state_d == RUN)) state_d = PAUSE;
            end
            PAUSE: if (start && !stop) state_d = RUN;
            default: ;
         endcase
      end
      running_d = (state_d == RUN);
      expired_d = (state_d == EXPIRED);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= IDLE;
         presc_q    <= '0;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
         expired_q  <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         running_q  <= running_d;
         done_q     <= done_d;
         expired_q  <= expired_d;
         load_err_q <= load_err_d;
      end
   end

   assign running = running_q;
   assign done    = done_q;
   assign expired = expired_q;
   assign loadErr = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer; the reference model keeps the
// count as plain seconds and converts to BCD only for comparison.
module tb_bcd_countdown_timer;

   localparam int TICK_DIV = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        load = 1'b0, start = 1'b0, stop = 1'b0;
   logic [23:0] setValue = 24'h0;
   logic [23:0] value;
   logic        running, done, expired, loadErr;
   logic [27:0] dut_vec;

   int total = 0;
   int bad   = 0;

   int m_secs, m_state, m_presc;
   bit m_done, m_err;

   bcd_countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
      .clk     (clk),
      .resetN  (resetN),
      .load    (load),
      .setValue(setValue),
      .start   (start),
      .stop    (stop),
      .value   (value),
      .running (running),
      .done    (done),
      .expired (expired),
      .loadErr (loadErr)
   );

   always #5 clk = ~clk;
   assign dut_vec = {value, running, done, expired, loadErr};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [23:0] to_bcd(input int s);
      int h, m, sec;
      h   = s / 3600;
      m   = (s / 60) % 60;
      sec = s % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
   endfunction

   function automatic bit time_ok(input logic [23:0] v);
      int d[6];
      for (int i = 0; i < 6; i++) d[i] = int'(v[4*i +: 4]);
      return (d[0] <= 9) && (d[1] <= 5) && (d[2] <= 9) && (d[3] <= 5) && (d[4] <= 9) &&
             (d[5] * 10 + d[4] <= 23);
   endfunction

   function automatic int to_secs(input logic [23:0] v);
      int d[6];
      for (int i = 0; i < 6; i++) d[i] = int'(v[4*i +: 4]);
      return (d[5] * 10 + d[4]) * 3600 + (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
   endfunction

   function automatic logic [27:0] model_out();
      return {to_bcd(m_secs), m_state == M_RUN, m_done, m_state == M_EXP, m_err};
   endfunction

   task automatic model_reset();
      m_secs = 0; m_state = M_IDLE; m_presc = 0; m_done = 0; m_err = 0;
   endtask

   // Drive one cycle of inputs from a negedge, advance the model at the posedge.
   task automatic step(input bit ld, input logic [23:0] sv, input bit st, input bit sp);
      load = ld; setValue = sv; start = st; stop = sp;
      @(posedge clk);
      m_done = 0;
      m_err  = 0;
      if (ld) begin
         if (time_ok(sv)) begin
            m_secs = to_secs(sv); m_state = M_IDLE; m_presc = 0;
         end else begin
            m_err = 1;
         end
      end else begin
         case (m_state)
            M_IDLE: if (st && !sp && m_secs != 0) begin
               m_state = M_RUN; m_presc = 0;
            end
            M_RUN: begin
               if (m_presc == TICK_DIV - 1) begin
                  m_presc = 0;
                  m_secs--;
                  if (m_secs == 0) begin
                     m_state = M_EXP; m_done = 1;
                  end
               end else begin
                  m_presc++;
               end
               if (sp && m_state == M_RUN) m_state = M_PAUSE;
            end
            M_PAUSE: if (st && !sp) m_state = M_RUN;
            default: ;
         endcase
      end
      @(negedge clk);
      load = 1'b0; start = 1'b0; stop = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      @(negedge clk);
      total++;
      if (dut_vec !== 28'h0) begin
         bad++; $display("FAIL reset_state got=%h exp=%h", dut_vec, 28'h0);
      end
      resetN = 1'b1;
      step(1, 24'h000500, 0, 0);
      step(0, 24'h0, 1, 0);
      repeat (7) step(0, 24'h0, 0, 0);
      total++;
      if (dut_vec !== model_out() || running !== 1'b1) begin
         bad++; $display("FAIL reset_prerun got=%h exp=%h", dut_vec, model_out());
      end
      #2 resetN = 1'b0;
      model_reset();
      #1;
      total++;
      if (dut_vec !== 28'h0) begin
         bad++; $display("FAIL reset_async got=%h exp=%h", dut_vec, 28'h0);
      end
      resetN = 1'b1;
      @(negedge clk);
      step(0, 24'h0, 0, 0);
      total++;
      if (dut_vec !== model_out()) begin
         bad++; $display("FAIL reset_idle got=%h exp=%h", dut_vec, model_out());
      end
   endtask

   task automatic test_expire();
      int done_cnt;
      bit done_aligned;
      done_cnt = 0;
      done_aligned = 1;
      step(1, 24'h000100, 0, 0);
      step(0, 24'h0, 1, 0);
      total++;
      if (running !== 1'b1) begin
         bad++; $display("FAIL start_running got=%b exp=1", running);
      end
      repeat (4) step(0, 24'h0, 0, 0);
      total++;
      if (value !== 24'h000059) begin
         bad++; $display("FAIL first_tick got=%h exp=%h", value, 24'h000059);
      end
      for (int c = 0; c < 250; c++) begin
         step(0, 24'h0, 0, 0);
         if (done === 1'b1) begin
            done_cnt++;
            if (value !== 24'h0 || expired !== 1'b1) done_aligned = 0;
         end
         total++;
         if (dut_vec !== model_out()) begin
            bad++; $display("FAIL expire_cycle%0d got=%h exp=%h", c, dut_vec, model_out());
         end
      end
      total++;
      if (done_cnt != 1 || !done_aligned) begin
         bad++; $display("FAIL done_pulse got=%0d aligned=%0d exp=1 aligned=1", done_cnt, done_aligned);
      end
      total++;
      if (expired !== 1'b1 || value !== 24'h0 || running !== 1'b0) begin
         bad++; $display("FAIL expired_hold got=%b/%h exp=1/000000", expired, value);
      end
   endtask

   task automatic test_borrow();
      step(1, 24'h100000, 0, 0);
      step(0, 24'h0, 1, 0);
      repeat (4) step(0, 24'h0, 0, 0);
      total++;
      if (value !== 24'h095959 || running !== 1'b1) begin
         bad++; $display("FAIL borrow_chain got=%h exp=%h", value, 24'h095959);
      end
   endtask

   task automatic test_load_validate();
      logic [23:0] bad_vals [4];
      bad_vals = '{24'h240000, 24'h006000, 24'h00000a, 24'h300000};
      step(1, 24'h000042, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, bad_vals[i], 0, 0);
         total++;
         if (loadErr !== 1'b1 || value !== 24'h000042 || dut_vec !== model_out()) begin
            bad++; $display("FAIL load_reject_%0d got=%h err=%b exp=%h err=1", i, value, loadErr, 24'h000042);
         end
      end
      step(0, 24'h0, 0, 0);
      total++;
      if (loadErr !== 1'b0) begin
         bad++; $display("FAIL load_err_pulse got=%b exp=0", loadErr);
      end
      step(1, 24'h235959, 0, 0);
      total++;
      if (value !== 24'h235959 || loadErr !== 1'b0) begin
         bad++; $display("FAIL load_max got=%h err=%b exp=%h err=0", value, loadErr, 24'h235959);
      end
   endtask

   task automatic test_pause_resume();
      step(1, 24'h000010, 0, 0);
      step(0, 24'h0, 1, 0);
      repeat (5) step(0, 24'h0, 0, 0);
      step(0, 24'h0, 0, 1);
      total++;
      if (running !== 1'b0 || value !== 24'h000009) begin
         bad++; $display("FAIL stop got=%b/%h exp=0/000009", running, value);
      end
      repeat (20) step(0, 24'h0, 0, 0);
      total++;
      if (value !== 24'h000009 || running !== 1'b0) begin
         bad++; $display("FAIL paused_hold got=%b/%h exp=0/000009", running, value);
      end
      step(0, 24'h0, 1, 0);
      step(0, 24'h0, 0, 0);
      total++;
      if (value !== 24'h000009 || running !== 1'b1) begin
         bad++; $display("FAIL resume_early got=%b/%h exp=1/000009", running, value);
      end
      step(0, 24'h0, 0, 0);
      total++;
      if (value !== 24'h000008) begin
         bad++; $display("FAIL resume_tick got=%h exp=%h", value, 24'h000008);
      end
   endtask

   task automatic test_priority();
      step(1, 24'h000030, 1, 0);
      total++;
      if (running !== 1'b0 || value !== 24'h000030) begin
         bad++; $display("FAIL load_start got=%b/%h exp=0/000030", running, value);
      end
      step(1, 24'h000000, 0, 0);
      step(0, 24'h0, 1, 0);
      total++;
      if (running !== 1'b0 || expired !== 1'b0) begin
         bad++; $display("FAIL start_zero got=%b exp=0", running);
      end
      step(1, 24'h000020, 0, 0);
      step(0, 24'h0, 1, 1);
      total++;
      if (running !== 1'b0) begin
         bad++; $display("FAIL idle_start_stop got=%b exp=0", running);
      end
      step(0, 24'h0, 1, 0);
      step(0, 24'h0, 0, 0);
      step(0, 24'h0, 1, 1);
      total++;
      if (running !== 1'b0 || dut_vec !== model_out()) begin
         bad++; $display("FAIL run_start_stop got=%h exp=%h", dut_vec, model_out());
      end
      repeat (6) step(0, 24'h0, 0, 0);
      total++;
      if (value !== 24'h000020) begin
         bad++; $display("FAIL pause_after_both got=%h exp=%h", value, 24'h000020);
      end
   endtask

   task automatic test_random();
      bit ld, st, sp;
      logic [23:0] sv;
      for (int c = 0; c < 500; c++) begin
         ld = ($urandom_range(0, 19) == 0);
         st = ($urandom_range(0, 5) == 0);
         sp = ($urandom_range(0, 11) == 0);
         case ($urandom_range(0, 3))
            0:       sv = 24'($urandom);
            1:       sv = to_bcd(int'($urandom_range(0, 86399)));
            default: sv = to_bcd(int'($urandom_range(0, 12)));
         endcase
         step(ld, sv, st, sp);
         total++;
         if (dut_vec !== model_out()) begin
            bad++; $display("FAIL random_cycle%0d got=%h exp=%h", c, dut_vec, model_out());
         end
      end
   endtask

   initial begin
      test_reset();
      test_expire();
      test_borrow();
      test_load_validate();
      test_pause_resume();
      test_priority();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Synchronous BCD countdown timer for the HH:MM:SS clock datapath. It is the decrementing counterpart of the existing per-digit incrementer chain. It loads a 24-hour BCD time value, counts it down once per prescaled tick using a borrow chain through six digits, and flags expiry at 00:00:00. It sits beside the time-of-day counter and drives the same seven-segment display mux.

## Interface
Parameters:
- TICK_DIV, 100000000: clk cycles per decrement (1 Hz at 100 MHz); must be ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- resetN  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle pulse; capture setValue.
- setValue  input  24  BCD {H1,H0,M1,M0,S1,S0}, 4 bits per digit.
- start  input  1  one-cycle pulse; begin or resume counting.
- stop  input  1  one-cycle pulse; pause counting.
- value  output  24  current BCD count, same digit order.
- running  output  1  high in RUN state.
- done  output  1  one-cycle pulse when the count reaches 00:00:00.
- expired  output  1  level, high in EXPIRED state.
- loadErr  output  1  one-cycle pulse when a load is rejected.

## Operation
- Reset (resetN low, asynchronous): value = 0, state IDLE, prescaler = 0. running, done, expired and loadErr are all 0.
- States:
  - IDLE: start with value ≠ 0 → RUN. start with value = 0 → ignored.
  - RUN: stop → PAUSE. Prescaler terminal count → decrement value. If the decrement produces 0 → EXPIRED.
  - PAUSE: start → RUN. The prescaler holds its count.
  - EXPIRED: value stays 0. Exits only via load or reset.
- load is accepted in any state and goes to IDLE. It clears the prescaler. It has priority over start and stop in the same cycle.
- start and stop asserted together: stop wins. The block stays in, or goes to, PAUSE if it was RUN; otherwise no change.
- Load validation:
  - Valid when S0 ≤ 9, S1 ≤ 5, M0 ≤ 9, M1 ≤ 5, H1 ≤ 2, H0 ≤ 9, and H0 ≤ 3 when H1 = 2.
  - An invalid load leaves value and state unchanged and pulses loadErr.
- Decrement borrow chain, LSB first. A digit at 0 reloads its maximum and borrows from the next digit; otherwise it subtracts 1 and the chain stops.
  - S0 max 9; S1 max 5; M0 max 9; M1 max 5; H0 max 9; H1 decrements with no wrap.
  - The 00:00:00 state is never decremented, so H1 never underflows.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - Decrement fires when prescaler = TICK_DIV-1; prescaler then returns to 0.
  - The prescaler is cleared on IDLE→RUN. It is not cleared on PAUSE→RUN.

## Timing
- All outputs are registered.
- load → value updated at the next rising edge. loadErr is high for one cycle in that same cycle.
- start in IDLE → running high the next cycle. The first decrement is visible TICK_DIV cycles after running rises.
- stop → running low the next cycle. A decrement coincident with stop still completes.
- done, expired and value = 0 are all visible at the same edge. done lasts one cycle; expired holds.
- The borrow chain resolves fully in one cycle; no intermediate digit values are visible.

## Structure
- Package timer_pkg: the state enum {IDLE, RUN, PAUSE, EXPIRED}, the digit maximum constants (9, 5, 9, 5, 9, 2), and HOUR_MAX_LOW = 3.
- Sub-module bcd_down_digit (instantiated ×6):
  - Inputs: dec, digit max. Output: borrow.
  - Registered 4-bit digit with synchronous load and async active-low reset.
  - H1 is instantiated with no reload.
- Top level: FSM, prescaler, load validator, output pulses.

## Test plan
All scenarios use TICK_DIV = 4.
- Reset mid-RUN at 00:05:00 → value = 0, state IDLE and all flags 0 immediately, without waiting for a clock edge.
- Load 00:01:00, start → after 4 cycles value = 00:00:59. After 60 ticks value = 0, done pulses once and expired stays high.
- Load 10:00:00, run 1 tick → 09:59:59, with the borrow crossing all five lower digits in one cycle.
- Load 24:00:00 → loadErr pulses and value is unchanged. Load 23:59:59 → accepted.
- Run from 00:00:10, stop after 6 cycles, wait 20 cycles, start → the next decrement arrives 2 cycles after resuming (prescaler held).
- Same-cycle load+start → IDLE with the new value. Start at value 0 → running stays 0. Same-cycle start+stop in RUN → PAUSE.
